// File: rtl/reorder_buffer_if.sv
// Issue, completion, operand-lookup and commit signals of the reorder buffer.
// The master side drives issue/cdb/lookup ids; the slave side is the buffer itself.
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 readyIn;
  logic                 issueValid;
  logic [4:0]           issueRd;
  logic                 issueStore;
  logic                 full;
  logic [ROB_WIDTH-1:0] issueId;
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbId;
  logic [31:0]          cdbValue;
  logic                 cdbMispredict;
  logic [31:0]          cdbRedirectPc;
  logic [ROB_WIDTH-1:0] qry1Id;
  logic [ROB_WIDTH-1:0] qry2Id;
  logic                 qry1Ready;
  logic                 qry2Ready;
  logic [31:0]          qry1Value;
  logic [31:0]          qry2Value;
  logic                 commitFlag;
  logic [ROB_WIDTH-1:0] commitId;
  logic [4:0]           commitAddr;
  logic [31:0]          commitValue;
  logic                 storeCommit;
  logic                 clearOut;
  logic [31:0]          redirectPc;

  modport master (
    output readyIn, issueValid, issueRd, issueStore,
    output cdbValid, cdbId, cdbValue, cdbMispredict, cdbRedirectPc,
    output qry1Id, qry2Id,
    input  full, issueId, qry1Ready, qry2Ready, qry1Value, qry2Value,
    input  commitFlag, commitId, commitAddr, commitValue, storeCommit,
    input  clearOut, redirectPc
  );

  modport slave (
    input  readyIn, issueValid, issueRd, issueStore,
    input  cdbValid, cdbId, cdbValue, cdbMispredict, cdbRedirectPc,
    input  qry1Id, qry2Id,
    output full, issueId, qry1Ready, qry2Ready, qry1Value, qry2Value,
    output commitFlag, commitId, commitAddr, commitValue, storeCommit,
    output clearOut, redirectPc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular entry store with result bypass,
// single-entry commit per cycle and full flush on a mispredicted commit.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input logic              clockIn,
  input logic              resetIn,
  reorder_buffer_if.slave  rob
);
  localparam int DEPTH = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = DEPTH[ROB_WIDTH:0];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH:0]   count;
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     ready;

  logic [4:0]           rdMem    [DEPTH];
  logic [31:0]          valueMem [DEPTH];
  logic [31:0]          pcMem    [DEPTH];
  logic [DEPTH-1:0]     storeBits;
  logic [DEPTH-1:0]     mispBits;

  logic                 issueFire_p0;
  logic                 cdbFire_p0;
  logic                 commitFire_p0;
  logic                 flushFire_p0;

  logic                 commitFlag_p1;
  logic [ROB_WIDTH-1:0] commitId_p1;
  logic [4:0]           commitAddr_p1;
  logic [31:0]          commitValue_p1;
  logic                 storeCommit_p1;
  logic                 clear_p1;
  logic [31:0]          redirectPc_p1;

  // ---- stage p0: per-cycle decisions from current state ----
  always_comb begin
    commitFire_p0 = rob.readyIn && (count != '0) && ready[head];
    flushFire_p0  = commitFire_p0 && mispBits[head];
    // A flush wins over anything else arriving in the same cycle.
    issueFire_p0  = rob.readyIn && rob.issueValid && (count != FULL_COUNT)
                    && !clear_p1 && !flushFire_p0;
    cdbFire_p0    = rob.readyIn && rob.cdbValid && busy[rob.cdbId] && !flushFire_p0;
  end

  assign rob.full    = (count == FULL_COUNT);
  assign rob.issueId = tail;

  // Lookups see a result broadcast in the same cycle before it is stored.
  assign rob.qry1Ready = ready[rob.qry1Id] || (rob.cdbValid && (rob.cdbId == rob.qry1Id));
  assign rob.qry2Ready = ready[rob.qry2Id] || (rob.cdbValid && (rob.cdbId == rob.qry2Id));
  assign rob.qry1Value = (rob.cdbValid && (rob.cdbId == rob.qry1Id)) ? rob.cdbValue
                                                                     : valueMem[rob.qry1Id];
  assign rob.qry2Value = (rob.cdbValid && (rob.cdbId == rob.qry2Id)) ? rob.cdbValue
                                                                     : valueMem[rob.qry2Id];

  // ---- stage p1: pointer/flag state and registered commit outputs ----
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      commitFlag_p1  <= 1'b0;
      commitId_p1    <= '0;
      commitAddr_p1  <= '0;
      commitValue_p1 <= '0;
      storeCommit_p1 <= 1'b0;
      clear_p1       <= 1'b0;
      redirectPc_p1  <= '0;
    end else if (rob.readyIn) begin
      commitFlag_p1  <= commitFire_p0 && (rdMem[head] != 5'd0);
      storeCommit_p1 <= commitFire_p0 && storeBits[head];
      clear_p1       <= flushFire_p0;
      if (commitFire_p0) begin
        commitId_p1    <= head;
        commitAddr_p1  <= rdMem[head];
        commitValue_p1 <= valueMem[head];
      end
      if (flushFire_p0) begin
        redirectPc_p1 <= pcMem[head];
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        busy          <= '0;
        ready         <= '0;
      end else begin
        if (issueFire_p0) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        if (cdbFire_p0) begin
          ready[rob.cdbId] <= 1'b1;
        end
        // Freeing the head comes last so it wins over a late cdb to that slot.
        if (commitFire_p0) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        case ({issueFire_p0, commitFire_p0})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Entry payload; validity is carried by busy/ready, so no reset here.
  always_ff @(posedge clockIn) begin
    if (issueFire_p0) begin
      rdMem[tail]     <= rob.issueRd;
      storeBits[tail] <= rob.issueStore;
      mispBits[tail]  <= 1'b0;
    end
    if (cdbFire_p0) begin
      valueMem[rob.cdbId] <= rob.cdbValue;
      mispBits[rob.cdbId] <= rob.cdbMispredict;
      pcMem[rob.cdbId]    <= rob.cdbRedirectPc;
    end
  end

  assign rob.commitFlag  = commitFlag_p1;
  assign rob.commitId    = commitId_p1;
  assign rob.commitAddr  = commitAddr_p1;
  assign rob.commitValue = commitValue_p1;
  assign rob.storeCommit = storeCommit_p1;
  assign rob.clearOut    = clear_p1;
  assign rob.redirectPc  = redirectPc_p1;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written corner sequences
// and randomized traffic against an in-order queue model of the buffer.
module tb_reorder_buffer;
  localparam int W     = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reorder_buffer_if #(.ROB_WIDTH(W)) bus ();
  reorder_buffer #(.ROB_WIDTH(W)) dut (.clockIn(clk), .resetIn(rst), .rob(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic        iv;
    logic [4:0]  ird;
    logic        ist;
    logic        cv;
    logic [3:0]  cid;
    logic [31:0] cval;
    logic        cmis;
    logic [31:0] cpc;
    logic [3:0]  eIssueId;
    logic        eFlag;
    logic        eStore;
    logic        eClear;
    logic [3:0]  eId;
    logic [4:0]  eAddr;
    logic [31:0] eVal;
    logic [31:0] ePc;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    bit          st;
    bit          rdy;
    logic [31:0] val;
    bit          mis;
    logic [31:0] pc;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic [3:0] mNext;
  bit mClear, mFlag, mStore;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.readyIn = 1'b1; bus.issueValid = 1'b0; bus.issueRd = '0; bus.issueStore = 1'b0;
    bus.cdbValid = 1'b0; bus.cdbId = '0; bus.cdbValue = '0; bus.cdbMispredict = 1'b0;
    bus.cdbRedirectPc = '0; bus.qry1Id = '0; bus.qry2Id = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issueValid = 1'b1; bus.issueRd = rd;
    tick();
    bus.issueValid = 1'b0;
  endtask

  function automatic int findIdx(input logic [3:0] id);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].id == id) return i;
    return -1;
  endfunction

  initial begin
    // ---------------- reset state ----------------
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_commitFlag", bus.commitFlag, 0);
    chk("rst_storeCommit", bus.storeCommit, 0);
    chk("rst_clearOut", bus.clearOut, 0);
    chk("rst_commitValue", bus.commitValue, 0);
    chk("rst_redirectPc", bus.redirectPc, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_issueId", bus.issueId, 0);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    vecs.push_back('{1,1,5,0, 0,0,0,0,0,          0, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,0,'h1234,0,0,     1, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          1, 1,0,0, 0,5,'h1234,0});
    vecs.push_back('{1,1,7,0, 0,0,0,0,0,          1, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,0,1, 0,0,0,0,0,          2, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,2,'hBEEF,0,0,     3, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          3, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,1,'h11,0,0,       3, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          3, 1,0,0, 1,7,'h11,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          3, 0,1,0, 2,0,'hBEEF,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          3, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,0,0, 0,0,0,0,0,          3, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,1,0, 0,0,0,0,0,          4, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,2,0, 0,0,0,0,0,          5, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,3,0, 0,0,0,0,0,          6, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,4,4,0,0,          7, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,5,5,0,0,          7, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,6,6,0,0,          7, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,3,0,1,'h100,      7, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,9,0, 0,0,0,0,0,          7, 0,0,1, 3,0,0,'h100});
    vecs.push_back('{1,1,9,0, 0,0,0,0,0,          0, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,9,0, 0,0,0,0,0,          0, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,0,5,0,0,          1, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          1, 1,0,0, 0,9,5,0});
    vecs.push_back('{1,1,4,0, 0,0,0,0,0,          1, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,1,6,0, 1,1,'h77,0,0,       2, 0,0,0, 0,0,0,0});
    vecs.push_back('{1,0,0,0, 1,2,'h66,0,0,       3, 1,0,0, 1,4,'h77,0});
    vecs.push_back('{0,1,8,0, 1,5,'h99,0,0,       3, 1,0,0, 1,4,'h77,0});
    vecs.push_back('{0,1,8,0, 1,5,'h99,0,0,       3, 1,0,0, 1,4,'h77,0});
    vecs.push_back('{0,1,8,0, 1,5,'h99,0,0,       3, 1,0,0, 1,4,'h77,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          3, 1,0,0, 2,6,'h66,0});
    vecs.push_back('{1,0,0,0, 0,0,0,0,0,          3, 0,0,0, 0,0,0,0});

    for (int i = 0; i < vecs.size(); i++) begin
      bus.readyIn = vecs[i].rdy; bus.issueValid = vecs[i].iv;
      bus.issueRd = vecs[i].ird; bus.issueStore = vecs[i].ist;
      bus.cdbValid = vecs[i].cv; bus.cdbId = vecs[i].cid; bus.cdbValue = vecs[i].cval;
      bus.cdbMispredict = vecs[i].cmis; bus.cdbRedirectPc = vecs[i].cpc;
      #1;
      chk($sformatf("vec%0d_issueId", i), bus.issueId, vecs[i].eIssueId);
      tick();
      chk($sformatf("vec%0d_commitFlag", i), bus.commitFlag, vecs[i].eFlag);
      chk($sformatf("vec%0d_storeCommit", i), bus.storeCommit, vecs[i].eStore);
      chk($sformatf("vec%0d_clearOut", i), bus.clearOut, vecs[i].eClear);
      if (vecs[i].eFlag || vecs[i].eStore) begin
        chk($sformatf("vec%0d_commitId", i), bus.commitId, vecs[i].eId);
        chk($sformatf("vec%0d_commitAddr", i), bus.commitAddr, vecs[i].eAddr);
        chk($sformatf("vec%0d_commitValue", i), bus.commitValue, vecs[i].eVal);
      end
      if (vecs[i].eClear)
        chk($sformatf("vec%0d_redirectPc", i), bus.redirectPc, vecs[i].ePc);
    end

    // ---------------- full buffer and wrap ----------------
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.issueValid = 1'b1; bus.issueRd = 5'(i + 1);
      #1;
      chk("fill_issueId", bus.issueId, i);
      chk("fill_notFull", bus.full, 0);
      tick();
    end
    chk("full_set", bus.full, 1);
    bus.issueRd = 5'd21;
    tick();
    chk("full_17th_ignored_full", bus.full, 1);
    chk("full_17th_ignored_id", bus.issueId, 0);
    bus.cdbValid = 1'b1; bus.cdbId = 4'd0; bus.cdbValue = 32'hA0;
    tick();
    bus.cdbValid = 1'b0;
    chk("full_after_cdb", bus.full, 1);
    tick();
    chk("full_commit_flag", bus.commitFlag, 1);
    chk("full_commit_id", bus.commitId, 0);
    chk("full_commit_value", bus.commitValue, 32'hA0);
    chk("full_issue_blocked", bus.full, 0);
    bus.issueRd = 5'd22;
    #1;
    chk("wrap_issueId", bus.issueId, 0);
    tick();
    bus.issueValid = 1'b0;
    chk("wrap_full", bus.full, 1);
    chk("wrap_next_id", bus.issueId, 1);

    // ---------------- lookup bypass, then reset mid-burst ----------------
    doReset();
    issue(5'd3); issue(5'd4); issue(5'd5);
    bus.qry1Id = 4'd2; bus.qry2Id = 4'd1;
    bus.cdbValid = 1'b1; bus.cdbId = 4'd2; bus.cdbValue = 32'd7;
    #1;
    chk("qry1_bypass_ready", bus.qry1Ready, 1);
    chk("qry1_bypass_value", bus.qry1Value, 7);
    chk("qry2_not_ready", bus.qry2Ready, 0);
    tick();
    bus.cdbValid = 1'b0;
    #1;
    chk("qry1_stored_ready", bus.qry1Ready, 1);
    chk("qry1_stored_value", bus.qry1Value, 7);
    bus.cdbValid = 1'b1; bus.cdbId = 4'd0; bus.cdbValue = 32'h55;
    tick();
    bus.cdbValid = 1'b0;
    tick();
    chk("pre_rst_commit", bus.commitFlag, 1);
    chk("pre_rst_value", bus.commitValue, 32'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_commitFlag", bus.commitFlag, 0);
    chk("midrst_commitAddr", bus.commitAddr, 0);
    chk("midrst_commitValue", bus.commitValue, 0);
    chk("midrst_issueId", bus.issueId, 0);
    chk("midrst_qry1Ready", bus.qry1Ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.issueValid = 1'b1; bus.issueRd = 5'd12;
    #1;
    chk("post_rst_issueId", bus.issueId, 0);
    tick();
    bus.issueValid = 1'b0;
    tick();
    chk("post_rst_no_stale_commit", bus.commitFlag, 0);
    bus.cdbValid = 1'b1; bus.cdbId = 4'd0; bus.cdbValue = 32'h3C;
    tick();
    bus.cdbValid = 1'b0;
    tick();
    chk("post_rst_commit_addr", bus.commitAddr, 12);
    chk("post_rst_commit_value", bus.commitValue, 32'h3C);
    tick();
    chk("post_rst_abandoned", bus.commitFlag, 0);

    // ---------------- randomized traffic vs queue model ----------------
    doReset();
    mq.delete(); mNext = '0; mClear = 0; mFlag = 0; mStore = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit com, fl, iss, cf, qr;
      int ci, qi;
      ent_t h, e;
      logic [3:0] eId;
      logic [4:0] eAddr;
      logic [31:0] eVal, ePc;
      bus.readyIn       = ($urandom_range(0, 9) != 0);
      bus.issueValid    = ($urandom_range(0, 2) != 0);
      bus.issueRd       = 5'($urandom_range(0, 31));
      bus.issueStore    = ($urandom_range(0, 3) == 0);
      bus.cdbValid      = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        bus.cdbId = mq[$urandom_range(0, mq.size() - 1)].id;
      else
        bus.cdbId = 4'($urandom_range(0, 15));
      bus.cdbValue      = $urandom;
      bus.cdbMispredict = ($urandom_range(0, 24) == 0);
      bus.cdbRedirectPc = $urandom;
      bus.qry1Id        = 4'($urandom_range(0, 15));
      bus.qry2Id        = (mq.size() > 0) ? mq[0].id : 4'($urandom_range(0, 15));
      #1;
      chk("rnd_full", bus.full, (mq.size() == DEPTH));
      chk("rnd_issueId", bus.issueId, mNext);
      qi = findIdx(bus.qry1Id);
      qr = (bus.cdbValid && bus.cdbId == bus.qry1Id) || (qi >= 0 && mq[qi].rdy);
      chk("rnd_qry1Ready", bus.qry1Ready, qr);
      if (qr)
        chk("rnd_qry1Value", bus.qry1Value,
            (bus.cdbValid && bus.cdbId == bus.qry1Id) ? bus.cdbValue : mq[qi].val);
      qi = findIdx(bus.qry2Id);
      qr = (bus.cdbValid && bus.cdbId == bus.qry2Id) || (qi >= 0 && mq[qi].rdy);
      chk("rnd_qry2Ready", bus.qry2Ready, qr);
      if (qr)
        chk("rnd_qry2Value", bus.qry2Value,
            (bus.cdbValid && bus.cdbId == bus.qry2Id) ? bus.cdbValue : mq[qi].val);

      com = 0; fl = 0; eId = '0; eAddr = '0; eVal = '0; ePc = '0;
      if (bus.readyIn) begin
        com = (mq.size() > 0) && mq[0].rdy;
        if (com) begin
          h = mq[0];
          eId = h.id; eAddr = h.rd; eVal = h.val; ePc = h.pc;
        end
        fl  = com && h.mis;
        iss = bus.issueValid && (mq.size() < DEPTH) && !mClear && !fl;
        ci  = findIdx(bus.cdbId);
        cf  = bus.cdbValid && (ci >= 0) && !fl;
        mFlag  = com && (h.rd != 0);
        mStore = com && h.st;
        mClear = fl;
        if (cf) begin
          mq[ci].rdy = 1; mq[ci].val = bus.cdbValue;
          mq[ci].mis = bus.cdbMispredict; mq[ci].pc = bus.cdbRedirectPc;
        end
        if (fl) begin
          mq.delete();
          mNext = '0;
        end else begin
          if (com) void'(mq.pop_front());
          if (iss) begin
            e.id = mNext; e.rd = bus.issueRd; e.st = bus.issueStore;
            e.rdy = 0; e.val = '0; e.mis = 0; e.pc = '0;
            mq.push_back(e);
            mNext = mNext + 4'd1;
          end
        end
      end
      tick();
      chk("rnd_commitFlag", bus.commitFlag, mFlag);
      chk("rnd_storeCommit", bus.storeCommit, mStore);
      chk("rnd_clearOut", bus.clearOut, mClear);
      if (com) begin
        chk("rnd_commitId", bus.commitId, eId);
        chk("rnd_commitAddr", bus.commitAddr, eAddr);
        chk("rnd_commitValue", bus.commitValue, eVal);
      end
      if (fl)
        chk("rnd_redirectPc", bus.redirectPc, ePc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
